// File: rtl/tim6_arb_pkg.sv
// Shared types for the tim6 APB arbiter: FSM states, requester index and
// the protection bit that marks a non-secure access.
package tim6_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DENY   = 2'd3
  } state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_M0 = 1'b0;
  localparam req_idx_t REQ_M1 = 1'b1;

  localparam int PROT_NS_BIT = 1;

endpackage

// File: rtl/tim6_rr_pick.sv
// Two-way request picker: round-robin against the last grant, or m0-first
// when fixed priority is selected. Output is one-hot or zero.
module tim6_rr_pick
  import tim6_arb_pkg::*;
(
  input  logic     [1:0] req,
  input  req_idx_t       last,
  input  logic           fixed,
  output logic     [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed || (last == REQ_M1)) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/tim6_apb_arb.sv
// Two-requester APB arbiter in front of the tim6 timer. Grants one requester at
// a time and blocks non-secure accesses while the timer is marked secure-only.
module tim6_apb_arb
  import tim6_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic [2:0]        m0_pprot,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [DATA_W-1:0] m1_pwdata,
  input  logic [2:0]        m1_pprot,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic              s_psel,
  output logic              s_penable,
  output logic [ADDR_W-1:0] s_paddr,
  output logic              s_pwrite,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic [DATA_W-1:0] s_prdata,
  input  logic              tipc_trust
);

  state_t            state, state_nxt;
  req_idx_t          last_grant, cur;
  logic [1:0]        gnt;
  req_idx_t          win;
  logic [ADDR_W-1:0] win_addr, lat_addr;
  logic              win_write, lat_write;
  logic [DATA_W-1:0] win_wdata, lat_wdata;
  logic [2:0]        win_prot;
  logic              grant, deny_now, done;
  logic [DATA_W-1:0] resp_data;
  logic              unused_penable;

  // Requesters are tracked by psel alone; penable adds nothing the FSM needs.
  assign unused_penable = m0_penable ^ m1_penable;

  tim6_rr_pick u_pick (
    .req   ({m1_psel, m0_psel}),
    .last  (last_grant),
    .fixed (FIXED_PRIO),
    .gnt   (gnt)
  );

  assign win       = gnt[1] ? REQ_M1 : REQ_M0;
  assign win_addr  = gnt[1] ? m1_paddr  : m0_paddr;
  assign win_write = gnt[1] ? m1_pwrite : m0_pwrite;
  assign win_wdata = gnt[1] ? m1_pwdata : m0_pwdata;
  assign win_prot  = gnt[1] ? m1_pprot  : m0_pprot;
  assign grant     = (state == IDLE) && (|gnt);
  assign deny_now  = tipc_trust && win_prot[PROT_NS_BIT];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|gnt) state_nxt = deny_now ? DENY : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      DENY:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trust is only looked at in the grant cycle, so the transfer in flight is fixed.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      last_grant <= REQ_M1;
      cur        <= REQ_M0;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= win;
        cur        <= win;
        lat_addr   <= win_addr;
        lat_write  <= win_write;
        lat_wdata  <= win_wdata;
      end
    end
  end

  assign s_psel    = (state == SETUP) || (state == ACCESS);
  assign s_penable = (state == ACCESS);
  assign s_paddr   = lat_addr;
  assign s_pwrite  = lat_write;
  assign s_pwdata  = lat_wdata;

  assign done      = (state == ACCESS) || (state == DENY);
  assign resp_data = (state == ACCESS) ? s_prdata : '0;

  always_comb begin
    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m0_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    m1_prdata  = '0;
    if (done) begin
      if (cur == REQ_M0) begin
        m0_pready  = 1'b1;
        m0_pslverr = (state == DENY);
        m0_prdata  = resp_data;
      end else begin
        m1_pready  = 1'b1;
        m1_pslverr = (state == DENY);
        m1_prdata  = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_tim6_apb_arb.sv
// Scoreboard bench for tim6_apb_arb: a round-robin instance and a fixed-priority
// instance share address/data/trust inputs but have separate psel lines.
module tb_tim6_apb_arb;

  typedef struct {
    int          cyc;
    logic        slverr;
    logic [31:0] prdata;
    logic        slave;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
  logic        m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
  logic        f_m0_psel = 1'b0, f_m0_penable = 1'b0;
  logic        f_m1_psel = 1'b0, f_m1_penable = 1'b0;
  logic [31:0] m0_paddr = '0, m0_pwdata = '0, m1_paddr = '0, m1_pwdata = '0;
  logic [2:0]  m0_pprot = '0, m1_pprot = '0;
  logic [31:0] s_prdata = '0;
  logic        tipc_trust = 1'b0;

  logic [31:0] m0_prdata, m1_prdata, f_m0_prdata, f_m1_prdata;
  logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
  logic        f_m0_pready, f_m0_pslverr, f_m1_pready, f_m1_pslverr;
  logic        s_psel, s_penable, s_pwrite, f_s_psel, f_s_penable, f_s_pwrite;
  logic [31:0] s_paddr, s_pwdata, f_s_paddr, f_s_pwdata;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_setup = 1'b0;
  logic done = 1'b0;
  logic final_done = 1'b0;
  exp_t q0[$], q1[$], q2[$], q3[$];

  tim6_apb_arb #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut (
    .pclk(pclk), .preset(preset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_pprot(m0_pprot), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
    .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_pprot(m1_pprot), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
    .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .tipc_trust(tipc_trust)
  );

  tim6_apb_arb #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fixed (
    .pclk(pclk), .preset(preset),
    .m0_psel(f_m0_psel), .m0_penable(f_m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_pprot(m0_pprot), .m0_prdata(f_m0_prdata), .m0_pready(f_m0_pready),
    .m0_pslverr(f_m0_pslverr),
    .m1_psel(f_m1_psel), .m1_penable(f_m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_pprot(m1_pprot), .m1_prdata(f_m1_prdata), .m1_pready(f_m1_pready),
    .m1_pslverr(f_m1_pslverr),
    .s_psel(f_s_psel), .s_penable(f_s_penable), .s_paddr(f_s_paddr), .s_pwrite(f_s_pwrite),
    .s_pwdata(f_s_pwdata), .s_prdata(s_prdata), .tipc_trust(tipc_trust)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Masters hold penable from the second cycle of a transfer until pready.
  always @(posedge pclk) begin
    m0_penable   <= m0_psel & ~m0_pready;
    m1_penable   <= m1_psel & ~m1_pready;
    f_m0_penable <= f_m0_psel & ~f_m0_pready;
    f_m1_penable <= f_m1_psel & ~f_m1_pready;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkPort(input int port, input logic pready, input logic slverr, input logic [31:0] prdata);
    exp_t  e;
    logic  empty;
    string nm;
    nm    = $sformatf("p%0d", port);
    empty = 1'b1;
    if (!pready) begin
      checkOutput({nm, "_idle_resp"}, prdata | {31'b0, slverr}, 32'd0);
    end else begin
      case (port)
        0: if (q0.size() != 0) begin e = q0.pop_front(); empty = 1'b0; end
        1: if (q1.size() != 0) begin e = q1.pop_front(); empty = 1'b0; end
        2: if (q2.size() != 0) begin e = q2.pop_front(); empty = 1'b0; end
        default: if (q3.size() != 0) begin e = q3.pop_front(); empty = 1'b0; end
      endcase
      if (empty) begin
        checkOutput({nm, "_unexpected_pready"}, {31'b0, pready}, 32'd0);
      end else begin
        checkOutput({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
        checkOutput({nm, "_slverr"}, {31'b0, slverr}, {31'b0, e.slverr});
        checkOutput({nm, "_prdata"}, prdata, e.prdata);
        if (port < 2) begin
          if (e.slave) begin
            checkOutput({nm, "_slave_phase"}, {29'b0, prev_setup, s_psel, s_penable}, 32'd7);
            checkOutput({nm, "_paddr"}, s_paddr, e.addr);
            checkOutput({nm, "_pwrite"}, {31'b0, s_pwrite}, {31'b0, e.write});
            checkOutput({nm, "_pwdata"}, s_pwdata, e.wdata);
          end else begin
            checkOutput({nm, "_deny_no_slave"}, {30'b0, s_psel, s_penable}, 32'd0);
          end
        end
      end
    end
  endtask

  // Monitor: reset-state checks while preset is high, scoreboard pops otherwise.
  always @(negedge pclk) begin
    if (preset) begin
      checkOutput("reset_main", {31'b0, |{s_psel, s_penable, s_paddr, s_pwrite, s_pwdata,
                  m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata}}, 32'd0);
      checkOutput("reset_fixed", {31'b0, |{f_s_psel, f_s_penable, f_s_paddr, f_s_pwrite, f_s_pwdata,
                  f_m0_pready, f_m0_pslverr, f_m0_prdata, f_m1_pready, f_m1_pslverr, f_m1_prdata}}, 32'd0);
    end else begin
      checkPort(0, m0_pready, m0_pslverr, m0_prdata);
      checkPort(1, m1_pready, m1_pslverr, m1_prdata);
      checkPort(2, f_m0_pready, f_m0_pslverr, f_m0_prdata);
      checkPort(3, f_m1_pready, f_m1_pslverr, f_m1_prdata);
    end
    prev_setup = s_psel && !s_penable;
    if (done && !final_done) begin
      checkOutput("pending_p0", 32'(q0.size()), 32'd0);
      checkOutput("pending_p1", 32'(q1.size()), 32'd0);
      checkOutput("pending_p2", 32'(q2.size()), 32'd0);
      checkOutput("pending_p3", 32'(q3.size()), 32'd0);
      final_done = 1'b1;
    end
  end

  task automatic atCycle(input int c);
    while (cyc < c) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic expectResp(input int port, input int at, input logic slverr, input logic [31:0] prdata,
                            input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    exp_t e;
    e.cyc = at; e.slverr = slverr; e.prdata = prdata; e.slave = !slverr;
    e.addr = addr; e.write = wr; e.wdata = wd;
    case (port)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic applyStimulus(input bit fx, input int m, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wd, input logic [2:0] prot);
    if (m == 0) begin
      m0_paddr = addr; m0_pwrite = wr; m0_pwdata = wd; m0_pprot = prot;
      if (fx) f_m0_psel = 1'b1; else m0_psel = 1'b1;
    end else begin
      m1_paddr = addr; m1_pwrite = wr; m1_pwdata = wd; m1_pprot = prot;
      if (fx) f_m1_psel = 1'b1; else m1_psel = 1'b1;
    end
  endtask

  task automatic releaseMaster(input bit fx, input int m);
    if (fx) begin
      if (m == 0) f_m0_psel = 1'b0; else f_m1_psel = 1'b0;
    end else begin
      if (m == 0) m0_psel = 1'b0; else m1_psel = 1'b0;
    end
  endtask

  task automatic doReset();
    int t;
    t = cyc;
    preset = 1'b1;
    atCycle(t + 2);
    preset = 1'b0;
  endtask

  task automatic runOne(input int m, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [2:0] prot, input int lat, input logic slverr, input logic [31:0] prdata);
    int t;
    t = cyc;
    applyStimulus(1'b0, m, addr, wr, wd, prot);
    expectResp(m, t + lat, slverr, prdata, addr, wr, wd);
    atCycle(t + lat);
    releaseMaster(1'b0, m);
    atCycle(t + lat + 1);
  endtask

  task automatic tie(input int first, input logic [31:0] rd);
    int t;
    t = cyc;
    applyStimulus(1'b0, 0, 32'h20, 1'b0, 32'h0, 3'b000);
    applyStimulus(1'b0, 1, 32'h24, 1'b0, 32'h0, 3'b000);
    expectResp(first, t + 2, 1'b0, rd, (first == 0) ? 32'h20 : 32'h24, 1'b0, 32'h0);
    expectResp(1 - first, t + 5, 1'b0, rd, (first == 0) ? 32'h24 : 32'h20, 1'b0, 32'h0);
    atCycle(t + 2);
    releaseMaster(1'b0, first);
    atCycle(t + 5);
    releaseMaster(1'b0, 1 - first);
    atCycle(t + 6);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    $display("[TB] starting tim6_apb_arb bench");
    atCycle(3);
    preset = 1'b0;

    // Single write and read, trust off.
    s_prdata = 32'h1234_5678;
    runOne(0, 32'h10, 1'b1, 32'hA5, 3'b000, 2, 1'b0, 32'h1234_5678);
    runOne(1, 32'h14, 1'b0, 32'h0, 3'b000, 2, 1'b0, 32'h1234_5678);

    // Round-robin ties from reset: m0 first, then winner alternates with last grant.
    doReset();
    s_prdata = 32'hCAFE_0001;
    tie(0, 32'hCAFE_0001);
    tie(0, 32'hCAFE_0001);
    runOne(0, 32'h28, 1'b1, 32'h55, 3'b000, 2, 1'b0, 32'hCAFE_0001);
    tie(1, 32'hCAFE_0001);
    tie(1, 32'hCAFE_0001);

    // Fixed priority with both requests held: m0 every round, m1 only after m0 leaves.
    doReset();
    s_prdata = 32'hF00D_0003;
    t = cyc;
    applyStimulus(1'b1, 0, 32'h30, 1'b0, 32'h0, 3'b000);
    applyStimulus(1'b1, 1, 32'h34, 1'b0, 32'h0, 3'b000);
    expectResp(2, t + 2, 1'b0, 32'hF00D_0003, 32'h30, 1'b0, 32'h0);
    expectResp(2, t + 5, 1'b0, 32'hF00D_0003, 32'h30, 1'b0, 32'h0);
    expectResp(2, t + 8, 1'b0, 32'hF00D_0003, 32'h30, 1'b0, 32'h0);
    expectResp(3, t + 11, 1'b0, 32'hF00D_0003, 32'h34, 1'b0, 32'h0);
    atCycle(t + 8);
    releaseMaster(1'b1, 0);
    atCycle(t + 11);
    releaseMaster(1'b1, 1);
    atCycle(t + 12);

    // Trust on: non-secure accesses denied in one cycle, secure ones pass.
    tipc_trust = 1'b1;
    s_prdata = 32'hDEAD_BEEF;
    runOne(1, 32'h40, 1'b0, 32'h0, 3'b010, 1, 1'b1, 32'h0);
    runOne(1, 32'h40, 1'b0, 32'h0, 3'b000, 2, 1'b0, 32'hDEAD_BEEF);
    runOne(0, 32'h44, 1'b1, 32'h77, 3'b011, 1, 1'b1, 32'h0);
    tipc_trust = 1'b0;

    // Reset during ACCESS aborts silently; held request is served after release.
    t = cyc;
    applyStimulus(1'b0, 0, 32'h50, 1'b0, 32'h0, 3'b000);
    atCycle(t + 2);
    preset = 1'b1;
    atCycle(t + 3);
    preset = 1'b0;
    expectResp(0, t + 5, 1'b0, 32'hDEAD_BEEF, 32'h50, 1'b0, 32'h0);
    atCycle(t + 5);
    releaseMaster(1'b0, 0);
    atCycle(t + 6);

    // Trust rises during SETUP: in-flight access completes, next one is denied.
    s_prdata = 32'h600D_0006;
    t = cyc;
    applyStimulus(1'b0, 1, 32'h60, 1'b0, 32'h0, 3'b010);
    expectResp(1, t + 2, 1'b0, 32'h600D_0006, 32'h60, 1'b0, 32'h0);
    atCycle(t + 1);
    tipc_trust = 1'b1;
    atCycle(t + 2);
    releaseMaster(1'b0, 1);
    atCycle(t + 3);
    runOne(1, 32'h60, 1'b0, 32'h0, 3'b010, 1, 1'b1, 32'h0);
    tipc_trust = 1'b0;

    atCycle(cyc + 3);
    done = 1'b1;
    repeat (2) @(posedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
